counter_timer: RTL

//  Memory-mapped down-counter/timer peripheral; responder end of the CPU bridge's counter port.

---
 rtl/counter_timer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/counter_timer.sv
// rtl/counter_timer.sv - memory-mapped down-counter/timer with prescaler and sticky status
// Optional interrupt output enabled by defining CNT_IRQ_EN.
module counter_timer #(
  parameter int CNT_W = 32,
  parameter int DIV_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [CNT_W-1:0] r_load;
  logic [CNT_W-1:0] r_value;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_pcnt;
  logic             r_en;
  logic             r_reload;
  logic             r_expired;
  logic             r_overrun;
`ifdef CNT_IRQ_EN
  logic             r_irq_en;
`endif

  logic w_wr_ctrl;
  logic w_wr_load;
  logic w_wr_stat;
  logic w_tick;
  logic w_tick_eff;
  logic w_expire;
  logic w_hw_stop;
  logic w_irq_en;
  logic w_unused;

  assign w_wr_ctrl = we && (addr[3:2] == 2'd0);
  assign w_wr_load = we && (addr[3:2] == 2'd1);
  assign w_wr_stat = we && (addr[3:2] == 2'd3);

  // A LOAD write on the same edge swallows the tick entirely, including expiry.
  assign w_tick     = r_en && (r_pcnt == r_div);
  assign w_tick_eff = w_tick && !w_wr_load;
  assign w_expire   = w_tick_eff && (r_value == CNT_W'(1));
  assign w_hw_stop  = w_tick_eff &&
                      (((r_value == CNT_W'(1)) && !r_reload) || (r_value == '0));

`ifdef CNT_IRQ_EN
  assign w_irq_en = r_irq_en;
  assign irq      = r_expired & r_irq_en;
`else
  assign w_irq_en = 1'b0;
  assign irq      = 1'b0;
`endif

  assign w_unused = ^{addr[31:4], addr[1:0], wdata};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_load    <= '0;
      r_value   <= '0;
      r_div     <= '0;
      r_pcnt    <= '0;
      r_en      <= 1'b0;
      r_reload  <= 1'b0;
      r_expired <= 1'b0;
      r_overrun <= 1'b0;
`ifdef CNT_IRQ_EN
      r_irq_en  <= 1'b0;
`endif
    end else begin
      if (w_wr_load || !r_en || w_tick) begin
        r_pcnt <= '0;
      end else begin
        r_pcnt <= r_pcnt + DIV_W'(1);
      end

      if (w_wr_ctrl) begin
        r_en     <= wdata[0];
        r_reload <= wdata[1];
        r_div    <= wdata[16 +: DIV_W];
`ifdef CNT_IRQ_EN
        r_irq_en <= wdata[2];
`endif
      end else if (w_hw_stop) begin
        r_en <= 1'b0;
      end

      if (w_wr_load) begin
        r_load  <= wdata[CNT_W-1:0];
        r_value <= wdata[CNT_W-1:0];
      end else if (w_tick) begin
        if (r_value > CNT_W'(1)) begin
          r_value <= r_value - CNT_W'(1);
        end else if (r_value == CNT_W'(1)) begin
          r_value <= r_reload ? r_load : '0;
        end
      end

      // Set terms are OR'ed after the clear so a same-edge expiry is never lost.
      r_expired <= (r_expired & ~(w_wr_stat & wdata[0])) | w_expire;
      r_overrun <= (r_overrun & ~(w_wr_stat & wdata[1])) | (w_expire & r_expired);
    end
  end

  always_comb begin
    rdata = '0;
    case (addr[3:2])
      2'd0: begin
        rdata[31:16] = 16'(r_div);
        rdata[2]     = w_irq_en;
        rdata[1]     = r_reload;
        rdata[0]     = r_en;
      end
      2'd1: rdata = 32'(r_load);
      2'd2: rdata = 32'(r_value);
      default: begin
        rdata[1] = r_overrun;
        rdata[0] = r_expired;
      end
    endcase
  end

endmodule
